// File: rtl/demux1x4_stripe.sv
// rtl/demux1x4_stripe.sv - round-robin 1-to-4 byte striper with idle flush of partial groups
module demux1x4_stripe #(
    parameter int IDLE_FLUSH = 4
) (
    input  logic       clk4f,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       validin,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [3:0] valid,
    output logic       out_strobe
);

    // Idle count value on the edge before the flush; the flush fires on the
    // edge where the count would reach IDLE_FLUSH.
    localparam logic [3:0] FLUSH_AT = 4'(IDLE_FLUSH - 1);

    logic [1:0] ptr;
    logic [7:0] staging [4];
    logic [3:0] mask;
    logic [3:0] idle_cnt;

    // Staging, lane pointer, idle counter and the registered output group
    always_ff @(posedge clk4f) begin
        if (reset) begin
            ptr        <= 2'd0;
            mask       <= 4'b0000;
            idle_cnt   <= 4'd0;
            staging[0] <= 8'h00;
            staging[1] <= 8'h00;
            staging[2] <= 8'h00;
            staging[3] <= 8'h00;
            out0       <= 8'h00;
            out1       <= 8'h00;
            out2       <= 8'h00;
            out3       <= 8'h00;
            valid      <= 4'b0000;
            out_strobe <= 1'b0;
        end else begin
            out_strobe <= 1'b0;
            if (validin) begin
                staging[ptr] <= in;
                idle_cnt     <= 4'd0;
                if (ptr == 2'd3) begin
                    // Last lane: the fourth byte bypasses staging straight to out3
                    out0       <= staging[0];
                    out1       <= staging[1];
                    out2       <= staging[2];
                    out3       <= in;
                    valid      <= 4'b1111;
                    out_strobe <= 1'b1;
                    ptr        <= 2'd0;
                    mask       <= 4'b0000;
                end else begin
                    mask[ptr] <= 1'b1;
                    ptr       <= ptr + 2'd1;
                end
            end else if (ptr != 2'd0) begin
                if (idle_cnt == FLUSH_AT) begin
                    // Partial group: unfilled lanes are zeroed and marked invalid
                    out0       <= mask[0] ? staging[0] : 8'h00;
                    out1       <= mask[1] ? staging[1] : 8'h00;
                    out2       <= mask[2] ? staging[2] : 8'h00;
                    out3       <= mask[3] ? staging[3] : 8'h00;
                    valid      <= mask;
                    out_strobe <= 1'b1;
                    ptr        <= 2'd0;
                    mask       <= 4'b0000;
                    idle_cnt   <= 4'd0;
                end else begin
                    idle_cnt <= idle_cnt + 4'd1;
                end
            end else begin
                idle_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_demux1x4_stripe.sv
// tb/tb_demux1x4_stripe.sv - directed table-driven bench for demux1x4_stripe
module tb_demux1x4_stripe;

    logic       clk4f = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic       validin;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] valid;
    logic       out_strobe;
    logic [7:0] f_out0, f_out1, f_out2, f_out3;
    logic [3:0] f_valid;
    logic       f_out_strobe;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       rst;
        logic       vin;
        logic [7:0] din;
        logic [7:0] e0, e1, e2, e3;
        logic [3:0] ev;
        logic       es;
    } vec_t;

    vec_t vecs[$];

    demux1x4_stripe #(.IDLE_FLUSH(4)) dut (
        .clk4f(clk4f), .reset(reset), .in(in), .validin(validin),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .valid(valid), .out_strobe(out_strobe)
    );

    demux1x4_stripe #(.IDLE_FLUSH(1)) dut_f1 (
        .clk4f(clk4f), .reset(reset), .in(in), .validin(validin),
        .out0(f_out0), .out1(f_out1), .out2(f_out2), .out3(f_out3),
        .valid(f_valid), .out_strobe(f_out_strobe)
    );

    always #5 clk4f = ~clk4f;

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3,
                       input logic [3:0] ev, input logic es);
        vec_t t;
        t.rst = r; t.vin = v; t.din = d;
        t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3; t.ev = ev; t.es = es;
        vecs.push_back(t);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk4f);
        reset   = r;
        validin = v;
        in      = d;
        @(posedge clk4f);
        #1;
    endtask

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got out0..3/valid/strobe=%h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] grp(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d,
                                        input logic [3:0] v, input logic s);
        return {a, b, c, d, v, s};
    endfunction

    initial begin
        logic [36:0] exp;
        reset = 1'b1; validin = 1'b0; in = 8'h00;

        // reset state
        add(1,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        // full group 11,22,33,44
        add(0,1,8'h11, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'h22, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'h33, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'h44, 8'h11,8'h22,8'h33,8'h44, 4'hF,1);
        add(0,0,8'h00, 8'h11,8'h22,8'h33,8'h44, 4'hF,0);
        // partial A1,B2 flushed on 4th idle edge
        add(0,1,8'hA1, 8'h11,8'h22,8'h33,8'h44, 4'hF,0);
        add(0,1,8'hB2, 8'h11,8'h22,8'h33,8'h44, 4'hF,0);
        for (int i = 0; i < 3; i++) add(0,0,8'h00, 8'h11,8'h22,8'h33,8'h44, 4'hF,0);
        add(0,0,8'h00, 8'hA1,8'hB2,8'h00,8'h00, 4'h3,1);
        add(0,0,8'h00, 8'hA1,8'hB2,8'h00,8'h00, 4'h3,0);
        // 3 idle cycles mid-group do not flush
        add(0,1,8'h55, 8'hA1,8'hB2,8'h00,8'h00, 4'h3,0);
        for (int i = 0; i < 3; i++) add(0,0,8'h00, 8'hA1,8'hB2,8'h00,8'h00, 4'h3,0);
        add(0,1,8'h66, 8'hA1,8'hB2,8'h00,8'h00, 4'h3,0);
        add(0,1,8'h77, 8'hA1,8'hB2,8'h00,8'h00, 4'h3,0);
        add(0,1,8'h88, 8'h55,8'h66,8'h77,8'h88, 4'hF,1);
        for (int i = 0; i < 5; i++) add(0,0,8'h00, 8'h55,8'h66,8'h77,8'h88, 4'hF,0);
        // single-byte flush then new group immediately after
        add(0,1,8'hE1, 8'h55,8'h66,8'h77,8'h88, 4'hF,0);
        for (int i = 0; i < 3; i++) add(0,0,8'h00, 8'h55,8'h66,8'h77,8'h88, 4'hF,0);
        add(0,0,8'h00, 8'hE1,8'h00,8'h00,8'h00, 4'h1,1);
        add(0,1,8'hF1, 8'hE1,8'h00,8'h00,8'h00, 4'h1,0);
        add(0,1,8'hF2, 8'hE1,8'h00,8'h00,8'h00, 4'h1,0);
        add(0,1,8'hF3, 8'hE1,8'h00,8'h00,8'h00, 4'h1,0);
        add(0,1,8'hF4, 8'hF1,8'hF2,8'hF3,8'hF4, 4'hF,1);
        // reset mid-group discards C bytes
        add(0,1,8'hC1, 8'hF1,8'hF2,8'hF3,8'hF4, 4'hF,0);
        add(0,1,8'hC2, 8'hF1,8'hF2,8'hF3,8'hF4, 4'hF,0);
        add(0,1,8'hC3, 8'hF1,8'hF2,8'hF3,8'hF4, 4'hF,0);
        add(1,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'hD1, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'hD2, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'hD3, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'hD4, 8'hD1,8'hD2,8'hD3,8'hD4, 4'hF,1);
        // reset wins over validin
        add(0,1,8'h07, 8'hD1,8'hD2,8'hD3,8'hD4, 4'hF,0);
        add(1,1,8'h99, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'h01, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'h02, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'h03, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        add(0,1,8'h04, 8'h01,8'h02,8'h03,8'h04, 4'hF,1);
        // reset wins over flush
        add(0,1,8'h08, 8'h01,8'h02,8'h03,8'h04, 4'hF,0);
        for (int i = 0; i < 3; i++) add(0,0,8'h00, 8'h01,8'h02,8'h03,8'h04, 4'hF,0);
        add(1,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);
        for (int i = 0; i < 5; i++) add(0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'h0,0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].vin, vecs[i].din);
            check($sformatf("vec%0d", i), {out0, out1, out2, out3, valid, out_strobe},
                  grp(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].ev, vecs[i].es));
        end

        // back-to-back bytes 00..0F: a strobe every 4th cycle
        step(1, 0, 8'h00);
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i));
            if (i % 4 == 3)
                exp = grp(8'(i-3), 8'(i-2), 8'(i-1), 8'(i), 4'hF, 1'b1);
            else
                exp[0] = 1'b0;
            check($sformatf("b2b%0d", i), {out0, out1, out2, out3, valid, out_strobe}, exp);
        end

        // 20 idle cycles after reset stay quiet
        step(1, 0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 8'hFF);
            check($sformatf("idle%0d", i), {out0, out1, out2, out3, valid, out_strobe},
                  grp(8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0));
        end

        // IDLE_FLUSH=1: the very first idle edge flushes
        step(1, 0, 8'h00);
        step(0, 1, 8'h5A);
        check("f1_stage", {f_out0, f_out1, f_out2, f_out3, f_valid, f_out_strobe},
              grp(8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0));
        step(0, 0, 8'h00);
        check("f1_flush", {f_out0, f_out1, f_out2, f_out3, f_valid, f_out_strobe},
              grp(8'h5A, 8'h00, 8'h00, 8'h00, 4'h1, 1'b1));
        check("f4_noflush", {out0, out1, out2, out3, valid, out_strobe},
              grp(8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0));
        step(0, 0, 8'h00);
        check("f1_hold", {f_out0, f_out1, f_out2, f_out3, f_valid, f_out_strobe},
              grp(8'h5A, 8'h00, 8'h00, 8'h00, 4'h1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
